accum_step_gen: RTL and testbench
=================================

Name: accum_step_gen

Overview:
Operand source for the 8-bit accumulator: turns a raw push-button and slide switches into clean one-cycle add strobes with a latched operand. It synchronizes and debounces the key, and emits exactly one step per press, with optional auto-repeat while the key is held. It sits between the board pins (KEY, SW) and the accumulator's clocking/enable input, replacing hand-pulsed clocks.

Parameters:
WIDTH, 8, operand and step_count width
DEBOUNCE_CYCLES, 500000, consecutive cycles a changed key level must persist before it is accepted (>=2)
REPEAT_DELAY, 25000000, cycles from first step to first auto-repeat step
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat steps

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
key_n  input  1  raw button, active-low (0 = pressed), asynchronous to clock
sw_in  input  WIDTH  raw operand switches
repeat_en  input  1  1 = auto-repeat while held
step  output  1  one-cycle strobe: accumulator adds operand this cycle
operand  output  WIDTH  sw_in captured at each step, held between steps
step_count  output  WIDTH  number of steps issued, modulo 2^WIDTH
key_held  output  1  debounced pressed level (1 = pressed)

Behaviour:
- Reset (reset=0, async): sync flops=1, stable level=released, debounce count=0, FSM=IDLE, step=0, operand=0, step_count=0, key_held=0.
- Sync: 2-flop synchronizer on key_n; key_sync is valid after the 2nd edge.
- Debounce: if key_sync==stable, count<=0. Else if count==DEBOUNCE_CYCLES-1, stable<=key_sync and count<=0. Else count++. Pulses shorter than DEBOUNCE_CYCLES are ignored.
- Latency: for key_n clean-low before edge 1, stable falls at edge 2+DEBOUNCE_CYCLES. step is high for the single cycle following edge 3+DEBOUNCE_CYCLES. Release follows the same timing; key_held tracks stable.
- FSM states:
  - IDLE: on stable press -> issue step, go to HELD.
  - HELD: repeat counter runs from the step. If repeat_en=1 and REPEAT_DELAY cycles have elapsed -> issue step, go to REPEAT. On stable release -> go to IDLE.
  - REPEAT: issue a step every REPEAT_PERIOD cycles. On stable release -> go to IDLE.
- Issuing a step: step<=1 for exactly one cycle; operand<=sw_in sampled on that same edge; step_count<=step_count+1, wrapping 255->0 with no flag.
- repeat_en=0 in HELD/REPEAT: no further steps, repeat counter held at 0, state stays until release. Re-asserting repeat_en restarts the REPEAT_DELAY count.
- Release and a due repeat on the same edge: release wins, no step.
- sw_in changes between steps do not affect operand.
- Reset mid-hold: everything clears. If the key is still held after reset release, it is treated as a new press: exactly one step after 3+DEBOUNCE_CYCLES edges.
- step never asserts on two consecutive cycles (requires DEBOUNCE_CYCLES>=2 and REPEAT_PERIOD>=2).

Decomposition:
- Shared package: WIDTH default, FSM state encoding (IDLE, HELD, REPEAT), default timing constants, plus reduced sim values (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
- Sub-module key_debounce: synchronizer + debounce counter; outputs stable level and one-cycle press/release pulses.
- Top: FSM, repeat counter, operand/step_count registers.

Test Plan:
(sim params D=4, RD=20, RP=8)
- Clean press: key_n=0 held, sw_in=8'h0F -> step high only after edge 7; operand=8'h0F, step_count=1. Ten presses/releases -> step_count=10, with an accumulator connected its out=8'h96.
- Bounce: key_n low for 3 cycles, high 2, low 3, then high -> no step, key_held stays 0. Followed by a 6-cycle-low press -> exactly one step.
- Auto-repeat: repeat_en=1, hold 60 cycles after first step -> steps at first-step edge +0, +20, +28, +36, +44, +52 (6 steps). Release -> no more. With repeat_en=0 the same hold gives exactly 1 step.
- Operand latch and wrap: step_count preloaded to 255 via 255 presses, one more press -> 0. sw_in toggled while no step is issued -> operand unchanged.
- Release/repeat collision: release timed so stable release coincides with a due repeat -> no step on that edge, FSM=IDLE.
- Reset mid-hold: assert reset in REPEAT with key held, deassert -> all outputs 0 immediately. Key still held -> one step 7 edges after reset release.

Source files
------------

// File: rtl/accum_step_gen_pkg.sv
// Shared constants, FSM encoding and sizing helper for the accumulator step generator.
package accum_step_gen_pkg;

    localparam int unsigned DefaultWidth          = 8;
    localparam int unsigned DefaultDebounceCycles = 500000;
    localparam int unsigned DefaultRepeatDelay    = 25000000;
    localparam int unsigned DefaultRepeatPeriod   = 5000000;

    // Short timings so simulation reaches repeats in tens of cycles.
    localparam int unsigned SimDebounceCycles = 4;
    localparam int unsigned SimRepeatDelay    = 20;
    localparam int unsigned SimRepeatPeriod   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StRepeat
    } step_state_e;

    // Bits needed to count from 0 to n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/accum_step_gen_key_debounce.sv
// Two-flop synchronizer plus level debouncer for an active-low key; emits registered
// one-cycle press/release pulses alongside the accepted level.
module accum_step_gen_key_debounce
    import accum_step_gen_pkg::*;
#(
    parameter int unsigned DebounceCycles = DefaultDebounceCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_n_i,
    output logic stable_n_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned CntW = cnt_width(DebounceCycles);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_n_q;
    logic            press_q;
    logic            release_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            stable_n_q <= 1'b1;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q   <= key_n_i;
            sync2_q   <= sync1_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (sync2_q == stable_n_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(DebounceCycles - 1)) begin
                stable_n_q <= sync2_q;
                cnt_q      <= '0;
                press_q    <= ~sync2_q;
                release_q  <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign stable_n_o = stable_n_q;
    assign press_o    = press_q;
    assign release_o  = release_q;

endmodule

// File: rtl/accum_step_gen.sv
// Turns a debounced push-button into one-cycle add strobes with optional auto-repeat,
// latching the switch operand and counting issued steps.
module accum_step_gen
    import accum_step_gen_pkg::*;
#(
    parameter int unsigned WIDTH           = DefaultWidth,
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned REPEAT_DELAY    = DefaultRepeatDelay,
    parameter int unsigned REPEAT_PERIOD   = DefaultRepeatPeriod
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_n,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             repeat_en,
    output logic             step,
    output logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] step_count,
    output logic             key_held
);

    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RptW   = cnt_width(RptMax);

    logic            stable_n;
    logic            key_press;
    logic            key_release;
    step_state_e     state_q;
    logic [RptW-1:0] rpt_cnt_q;
    logic [RptW-1:0] rpt_limit;
    logic            wait_delay_q;

    accum_step_gen_key_debounce #(
        .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk_i     (clock),
        .rst_ni    (reset),
        .key_n_i   (key_n),
        .stable_n_o(stable_n),
        .press_o   (key_press),
        .release_o (key_release)
    );

    // Re-enabling repeat after a pause in REPEAT waits the full initial delay again.
    always_comb begin
        rpt_limit = RptW'(REPEAT_PERIOD - 1);
        if (state_q == StHeld || wait_delay_q) begin
            rpt_limit = RptW'(REPEAT_DELAY - 1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            rpt_cnt_q    <= '0;
            wait_delay_q <= 1'b0;
            step         <= 1'b0;
            operand      <= '0;
            step_count   <= '0;
        end else begin
            step <= 1'b0;
            case (state_q)
                StIdle: begin
                    rpt_cnt_q    <= '0;
                    wait_delay_q <= 1'b0;
                    if (key_press) begin
                        step       <= 1'b1;
                        operand    <= sw_in;
                        step_count <= step_count + WIDTH'(1);
                        state_q    <= StHeld;
                    end
                end
                StHeld, StRepeat: begin
                    if (key_release) begin
                        state_q   <= StIdle;
                        rpt_cnt_q <= '0;
                    end else if (!repeat_en) begin
                        rpt_cnt_q <= '0;
                        if (state_q == StRepeat) begin
                            wait_delay_q <= 1'b1;
                        end
                    end else if (rpt_cnt_q == rpt_limit) begin
                        step         <= 1'b1;
                        operand      <= sw_in;
                        step_count   <= step_count + WIDTH'(1);
                        state_q      <= StRepeat;
                        rpt_cnt_q    <= '0;
                        wait_delay_q <= 1'b0;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign key_held = ~stable_n;

endmodule

// File: tb/tb_accum_step_gen.sv
// Directed bench for accum_step_gen using the reduced simulation timings.
module tb_accum_step_gen;
    import accum_step_gen_pkg::*;

    logic       clock;
    logic       reset;
    logic       key_n;
    logic [7:0] sw_in;
    logic       repeat_en;
    logic       step;
    logic [7:0] operand;
    logic [7:0] step_count;
    logic       key_held;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         step_q[$];
    logic       prev_step = 1'b0;
    logic [7:0] acc = 8'h00;
    logic       held_seen = 1'b0;
    int         exp_count = 0;
    int         base;
    int         rep_off[6] = '{0, 20, 28, 36, 44, 52};

    accum_step_gen #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(SimDebounceCycles),
        .REPEAT_DELAY   (SimRepeatDelay),
        .REPEAT_PERIOD  (SimRepeatPeriod)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key_n     (key_n),
        .sw_in     (sw_in),
        .repeat_en (repeat_en),
        .step      (step),
        .operand   (operand),
        .step_count(step_count),
        .key_held  (key_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // step observed in the cycle after edge cyc; model accumulator adds it
    always @(negedge clock) begin
        if (key_held) held_seen <= 1'b1;
        if (step) begin
            check("no_back_to_back", 32'(prev_step), 32'd0);
            step_q.push_back(cyc);
            acc <= acc + operand;
        end
        prev_step <= step;
    end

    task automatic press_cycle(input int low, input int high, input logic [7:0] sw);
        key_n = 1'b0;
        sw_in = sw;
        repeat (low) @(negedge clock);
        key_n = 1'b1;
        repeat (high) @(negedge clock);
    endtask

    initial begin
        reset     = 1'b0;
        key_n     = 1'b1;
        sw_in     = 8'h00;
        repeat_en = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_step", 32'(step), 32'd0);
        check("rst_operand", 32'(operand), 32'd0);
        check("rst_count", 32'(step_count), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Clean press: step in the cycle after edge 7
        step_q.delete();
        base  = cyc;
        key_n = 1'b0;
        sw_in = 8'h0F;
        repeat (12) @(negedge clock);
        check("clean_n_steps", step_q.size(), 1);
        if (step_q.size() > 0) check("clean_step_edge", step_q[0] - base, 7);
        check("clean_held", 32'(key_held), 32'd1);
        check("clean_operand", 32'(operand), 32'h0F);
        check("clean_count", 32'(step_count), 32'd1);
        key_n = 1'b1;
        repeat (12) @(negedge clock);
        check("clean_release_held", 32'(key_held), 32'd0);
        for (int i = 0; i < 9; i++) press_cycle(8, 10, 8'h0F);
        exp_count = 10;
        check("ten_count", 32'(step_count), 32'(exp_count));
        check("ten_acc", 32'(acc), 32'h96);

        // Bounce shorter than the debounce window is ignored
        step_q.delete();
        held_seen <= 1'b0;
        @(negedge clock);
        press_cycle(3, 2, 8'h22);
        press_cycle(3, 12, 8'h22);
        check("bounce_n_steps", step_q.size(), 0);
        check("bounce_held", 32'(held_seen), 32'd0);
        press_cycle(6, 12, 8'h22);
        exp_count++;
        check("bounce_then_press", step_q.size(), 1);
        check("bounce_count", 32'(step_count), 32'(exp_count));
        check("bounce_operand", 32'(operand), 32'h22);

        // Auto-repeat: release seen by the FSM at first-step edge +56
        repeat_en = 1'b1;
        step_q.delete();
        base  = cyc;
        key_n = 1'b0;
        sw_in = 8'h01;
        repeat (56) @(negedge clock);
        key_n = 1'b1;
        repeat (40) @(negedge clock);
        check("rpt_n_steps", step_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < step_q.size()) check("rpt_step_edge", step_q[i] - base, 7 + rep_off[i]);
        end
        exp_count += 6;
        check("rpt_count", 32'(step_count), 32'(exp_count));

        // Same hold without repeat
        repeat_en = 1'b0;
        step_q.delete();
        base  = cyc;
        key_n = 1'b0;
        repeat (56) @(negedge clock);
        key_n = 1'b1;
        repeat (40) @(negedge clock);
        check("norpt_n_steps", step_q.size(), 1);
        if (step_q.size() > 0) check("norpt_step_edge", step_q[0] - base, 7);
        exp_count++;

        // Drive count to 255, then wrap
        for (int i = exp_count; i < 255; i++) press_cycle(8, 10, 8'h33);
        check("pre_wrap_count", 32'(step_count), 32'd255);
        press_cycle(8, 10, 8'hA5);
        check("wrap_count", 32'(step_count), 32'd0);
        check("wrap_operand", 32'(operand), 32'hA5);
        sw_in = 8'h5A;
        repeat (10) @(negedge clock);
        sw_in = 8'hC3;
        repeat (10) @(negedge clock);
        check("latch_operand", 32'(operand), 32'hA5);
        check("latch_count", 32'(step_count), 32'd0);

        // Release lands on the edge where the first repeat is due
        repeat_en = 1'b1;
        step_q.delete();
        base  = cyc;
        key_n = 1'b0;
        sw_in = 8'h11;
        repeat (20) @(negedge clock);
        key_n = 1'b1;
        repeat (30) @(negedge clock);
        check("coll_n_steps", step_q.size(), 1);
        if (step_q.size() > 0) check("coll_step_edge", step_q[0] - base, 7);
        check("coll_state", 32'(dut.state_q), 32'(StIdle));
        check("coll_count", 32'(step_count), 32'd1);
        step_q.delete();
        base  = cyc;
        key_n = 1'b0;
        repeat (12) @(negedge clock);
        key_n = 1'b1;
        repeat (20) @(negedge clock);
        check("coll_next_n", step_q.size(), 1);
        if (step_q.size() > 0) check("coll_next_edge", step_q[0] - base, 7);

        // Reset while repeating with the key held
        key_n = 1'b0;
        repeat (31) @(negedge clock);
        check("pre_reset_state", 32'(dut.state_q), 32'(StRepeat));
        reset = 1'b0;
        #1;
        check("midrst_step", 32'(step), 32'd0);
        check("midrst_operand", 32'(operand), 32'd0);
        check("midrst_count", 32'(step_count), 32'd0);
        check("midrst_held", 32'(key_held), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        step_q.delete();
        base = cyc;
        check("postrst_count", 32'(step_count), 32'd0);
        check("postrst_held", 32'(key_held), 32'd0);
        repeat (15) @(negedge clock);
        check("postrst_n_steps", step_q.size(), 1);
        if (step_q.size() > 0) check("postrst_step_edge", step_q[0] - base, 7);
        check("postrst_count1", 32'(step_count), 32'd1);
        key_n = 1'b1;
        repeat (15) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
